regfile_wb_arbiter: RTL and testbench

//  Write-port scheduler for the 32x32 register file. NREQ write-back requesters share one write port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter:
// default geometry, the hard-wired zero register index and a
// round-robin wrap helper.
package regfile_wb_arbiter_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  // r0 reads as zero; writes to it are swallowed.
  localparam int R0_IDX   = 0;

  // Index that follows idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and
// wraps modulo NREQ; the first valid requester wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   grant_idx_o,
  output logic            any_grant_o
);

  // Priority search starting at the pointer, wrapping around.
  always_comb begin
    int j;
    j           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_grant_o && valid_i[j]) begin
        grant_o[j]  = 1'b1;
        grant_idx_o = PW'(j);
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port scheduler for the register file. NREQ write-back
// requesters share one write port: round-robin grant, one registered
// write stage driving a one-hot per-register write enable and shared
// write data. Writes to r0 and to addresses beyond the file are dropped.
// Optional feature macro: WB_BYPASS_EN (adds read-address compare
// ports and the write-cycle bypass outputs).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREG-1:0]   reg_we,
  output logic [DW-1:0]     reg_wdata
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic              byp_hit_a,
  output logic              byp_hit_b,
  output logic [DW-1:0]     byp_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            any_grant;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // One-hot write enable for an address; r0 and out-of-range decode to zero.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int r = 0; r < NREG; r++) begin
      if (a == AW'(r) && r != R0_IDX) oh[r] = 1'b1;
    end
    return oh;
  endfunction

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .valid_i     (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // Handshake is held off entirely while clr is asserted.
  assign req_ready = clr ? '0 : grant;
  assign accept    = any_grant && !clr;

  // Steer the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Next-state: pointer advance, write enable and data capture on accept.
  always_comb begin
    ptr_d   = ptr_q;
    we_d    = '0;
    wdata_d = wdata_q;
    if (accept) begin
      ptr_d   = PW'(rr_next(int'(grant_idx), NREQ));
      we_d    = onehot(sel_addr);
      wdata_d = sel_data;
    end
  end

  // Write stage register: accept at edge N presents the write in cycle N+1.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // A pending write is dropped as soon as clr is seen.
  assign reg_we    = clr ? '0 : we_q;
  assign reg_wdata = wdata_q;

`ifdef WB_BYPASS_EN
  // Readers of the register being written this cycle see the new value.
  always_comb begin
    byp_hit_a = |(reg_we & onehot(rd_addr_a));
    byp_hit_b = |(reg_we & onehot(rd_addr_b));
    byp_data  = wdata_q;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               clr;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREG-1:0]    reg_we;
  logic [DW-1:0]      reg_wdata;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]      rd_addr_a, rd_addr_b;
  logic               byp_hit_a, byp_hit_b;
  logic [DW-1:0]      byp_data;
`endif

  regfile_wb_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata)
`ifdef WB_BYPASS_EN
    ,
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .byp_hit_a (byp_hit_a),
    .byp_hit_b (byp_hit_b),
    .byp_data  (byp_data)
`endif
  );

  always #5 clk = ~clk;

  // Requester-side pending transactions (held stable until granted).
  logic            pend_v [NREQ];
  logic [AW-1:0]   pend_a [NREQ];
  logic [DW-1:0]   pend_d [NREQ];

  // Reference model state.
  int              m_ptr;
  logic [NREG-1:0] m_we;
  logic [DW-1:0]   m_wdata;
  int              last_w;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] a);
    if (a != 0 && int'(a) < NREG) return NREG'(1) << a;
    return '0;
  endfunction

  // Requester that the round-robin rule picks: first pending at or after the pointer.
  function automatic int winner();
    for (int k = 0; k < NREQ; k++) begin
      if (pend_v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend_v[i];
      req_addr[i*AW +: AW]  = pend_a[i];
      req_data[i*DW +: DW]  = pend_d[i];
    end
  endtask

  // Compare DUT against the model at the falling edge.
  task automatic sample();
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic [NREG-1:0] exp_we;
    @(negedge clk);
    w = winner();
    exp_rdy = (clr || w < 0) ? '0 : NREQ'(1) << w;
    exp_we  = clr ? '0 : m_we;
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    chk("we",    64'(reg_we),    64'(exp_we));
    chk("wdata", 64'(reg_wdata), 64'(m_wdata));
`ifdef WB_BYPASS_EN
    chk("hit_a", 64'(byp_hit_a), 64'(exp_we[rd_addr_a] && rd_addr_a != 0));
    chk("hit_b", 64'(byp_hit_b), 64'(exp_we[rd_addr_b] && rd_addr_b != 0));
    chk("bdata", 64'(byp_data),  64'(m_wdata));
`endif
  endtask

  // Rising edge: update the model and retire the accepted request.
  task automatic advance();
    int w;
    w = winner();
    @(posedge clk);
    last_w = -1;
    if (clr) begin
      m_ptr = 0; m_we = '0; m_wdata = '0;
    end else if (w >= 0) begin
      m_we      = decode(pend_a[w]);
      m_wdata   = pend_d[w];
      m_ptr     = (w + 1) % NREQ;
      pend_v[w] = 1'b0;
      last_w    = w;
    end else begin
      m_we = '0;
    end
    #1;
    drive();
  endtask

  initial begin
    m_ptr = 0; m_we = '0; m_wdata = '0; last_w = -1;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
    end
`ifdef WB_BYPASS_EN
    rd_addr_a = '0; rd_addr_b = '0;
`endif
    clr = 1'b1;
    pend_v[0] = 1'b1; pend_a[0] = 5'd1; pend_d[0] = 32'h11;
    pend_v[1] = 1'b1; pend_a[1] = 5'd2; pend_d[1] = 32'h22;
    drive();
    @(posedge clk); #1;
    advance();

    // Reset held with both requesters valid.
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_we",    64'(reg_we),    64'h0);
      chk("rst_wdata", 64'(reg_wdata), 64'h0);
      advance();
    end
    clr = 1'b0;
    drive();
    sample();
    chk("post_rst_grant0", 64'(req_ready), 64'h1);
    advance();
    sample();
    advance();

    // r0 write: handshakes, no enable, pointer returns to 0.
    pend_v[1] = 1'b1; pend_a[1] = 5'd0; pend_d[1] = 32'h1234;
    drive();
    sample();
    chk("r0_ready", 64'(req_ready), 64'h2);
    advance();
    sample();
    chk("r0_we", 64'(reg_we), 64'h0);
    advance();

    // Full contention: grants alternate 0,1,0,1.
    pend_v[0] = 1'b1; pend_a[0] = 5'd3; pend_d[0] = 32'h3333;
    pend_v[1] = 1'b1; pend_a[1] = 5'd7; pend_d[1] = 32'h7777;
    drive();
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("cont_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) chk("cont_we", 64'(reg_we), (k % 2 == 1) ? 64'h8 : 64'h80);
      advance();
      if (k < 2 && last_w >= 0) begin
        pend_v[last_w] = 1'b1;
        drive();
      end
    end
    sample();
    chk("cont_we_last", 64'(reg_we), 64'h80);
    advance();

    // Single write, visible for exactly one cycle.
    pend_v[0] = 1'b1; pend_a[0] = 5'd5; pend_d[0] = 32'hDEADBEEF;
    drive();
    sample();
    chk("single_ready", 64'(req_ready), 64'h1);
    advance();
    sample();
    chk("single_we",    64'(reg_we),    64'h20);
    chk("single_wdata", 64'(reg_wdata), 64'hDEADBEEF);
    advance();
    sample();
    chk("single_we_off", 64'(reg_we),    64'h0);
    chk("single_hold",   64'(reg_wdata), 64'hDEADBEEF);
    advance();

    // clr right after accepting a write to r9 loses the write.
    pend_v[1] = 1'b1; pend_a[1] = 5'd9; pend_d[1] = 32'h9999;
    drive();
    sample();
    advance();
    clr = 1'b1;
    drive();
    sample();
    chk("clr_we", 64'(reg_we), 64'h0);
    advance();
    clr = 1'b0;
    drive();
    sample();
    chk("clr_we_after", 64'(reg_we), 64'h0);
    advance();

`ifdef WB_BYPASS_EN
    // Bypass on the write cycle.
    pend_v[0] = 1'b1; pend_a[0] = 5'd12; pend_d[0] = 32'hA5A5A5A5;
    rd_addr_a = 5'd12; rd_addr_b = 5'd0;
    drive();
    sample();
    advance();
    sample();
    chk("byp_a",    64'(byp_hit_a), 64'h1);
    chk("byp_b",    64'(byp_hit_b), 64'h0);
    chk("byp_data", 64'(byp_data),  64'hA5A5A5A5);
    advance();
`endif

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && ($urandom % 2 == 0)) begin
          pend_v[i] = 1'b1;
          pend_a[i] = AW'($urandom_range(0, NREG - 1));
          pend_d[i] = $urandom;
        end
      end
      clr = ($urandom % 40 == 0);
`ifdef WB_BYPASS_EN
      rd_addr_a = AW'($urandom);
      rd_addr_b = AW'($urandom);
`endif
      drive();
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
